// File: rtl/cache_refill.sv
// cache_refill: single-outstanding read path that looks up the cache, reads a hit from cache RAM,
// or fetches a miss from main memory and refills one word. Optional stats: CACHE_REFILL_STAT_EN.
`default_nettype none

module cache_refill (
  input  logic        i_clk,
  input  logic        i_nreset,
  input  logic        i_req,
  input  logic [29:0] i_addr,
  output logic        o_ready,
  output logic        o_valid,
  output logic [31:0] o_rdata,
  output logic        o_en,
  output logic        o_change_block,
  output logic        o_ready_wr,
  input  logic        i_miss_cache,
  input  logic [7:0]  i_cache_addr,
  output logic        o_cram_re,
  output logic        o_cram_we,
  output logic [7:0]  o_cram_addr,
  output logic [31:0] o_cram_wdata,
  input  logic [31:0] i_cram_rdata,
  output logic        o_mem_req,
  output logic [29:0] o_mem_addr,
`ifdef CACHE_REFILL_STAT_EN
  output logic [15:0] o_hit_cnt,
  output logic [15:0] o_miss_cnt,
`endif
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOOKUP  = 3'd1;
  localparam logic [2:0] ST_HIT_RD  = 3'd2;
  localparam logic [2:0] ST_MEM_REQ = 3'd3;
  localparam logic [2:0] ST_FILL    = 3'd4;
  localparam logic [2:0] ST_RESP    = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [7:0]  caddr_q, caddr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rdata_q, rdata_d;

  assign o_rdata = rdata_q;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    caddr_d        = caddr_q;
    data_d         = data_q;
    rdata_d        = rdata_q;
    o_ready        = 1'b0;
    o_valid        = 1'b0;
    o_en           = 1'b0;
    o_change_block = 1'b0;
    o_ready_wr     = 1'b0;
    o_cram_re      = 1'b0;
    o_cram_we      = 1'b0;
    o_cram_addr    = 8'd0;
    o_cram_wdata   = 32'd0;
    o_mem_req      = 1'b0;
    o_mem_addr     = 30'd0;
    case (state_q)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_req) begin
          addr_d  = i_addr;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        o_en           = 1'b1;
        o_change_block = 1'b1;
        if (i_miss_cache) begin
          caddr_d = i_cache_addr;
          state_d = ST_MEM_REQ;
        end else begin
          o_cram_re   = 1'b1;
          o_cram_addr = i_cache_addr;
          state_d     = ST_HIT_RD;
        end
      end
      ST_HIT_RD: begin
        rdata_d = i_cram_rdata;
        state_d = ST_RESP;
      end
      ST_MEM_REQ: begin
        // Address held from addr_q so it stays stable for the whole wait.
        o_mem_req  = 1'b1;
        o_mem_addr = addr_q;
        if (i_mem_ack) begin
          data_d  = i_mem_rdata;
          rdata_d = i_mem_rdata;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        o_cram_we    = 1'b1;
        o_cram_addr  = caddr_q;
        o_cram_wdata = data_q;
        o_ready_wr   = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        o_valid = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nreset) begin
      state_q <= ST_IDLE;
      addr_q  <= 30'd0;
      caddr_q <= 8'd0;
      data_q  <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      caddr_q <= caddr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef CACHE_REFILL_STAT_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  assign o_hit_cnt  = hit_cnt_q;
  assign o_miss_cnt = miss_cnt_q;

  // Saturating event counters sampled on the single lookup cycle.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == ST_LOOKUP) begin
      if (i_miss_cache) begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
      end else begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nreset) begin
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_refill.sv
// tb_cache_refill: randomized self-checking bench; the bench plays cache calculator, cache RAM and
// main memory, and predicts latency, refill writes and response data from the request description.
`default_nettype none

module tb_cache_refill;

  logic        i_clk;
  logic        i_nreset;
  logic        i_req;
  logic [29:0] i_addr;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_rdata;
  logic        o_en;
  logic        o_change_block;
  logic        o_ready_wr;
  logic        i_miss_cache;
  logic [7:0]  i_cache_addr;
  logic        o_cram_re;
  logic        o_cram_we;
  logic [7:0]  o_cram_addr;
  logic [31:0] o_cram_wdata;
  logic [31:0] i_cram_rdata;
  logic        o_mem_req;
  logic [29:0] o_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
`ifdef CACHE_REFILL_STAT_EN
  logic [15:0] o_hit_cnt;
  logic [15:0] o_miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  cache_refill dut (
    .i_clk          (i_clk),
    .i_nreset       (i_nreset),
    .i_req          (i_req),
    .i_addr         (i_addr),
    .o_ready        (o_ready),
    .o_valid        (o_valid),
    .o_rdata        (o_rdata),
    .o_en           (o_en),
    .o_change_block (o_change_block),
    .o_ready_wr     (o_ready_wr),
    .i_miss_cache   (i_miss_cache),
    .i_cache_addr   (i_cache_addr),
    .o_cram_re      (o_cram_re),
    .o_cram_we      (o_cram_we),
    .o_cram_addr    (o_cram_addr),
    .o_cram_wdata   (o_cram_wdata),
    .i_cram_rdata   (i_cram_rdata),
    .o_mem_req      (o_mem_req),
    .o_mem_addr     (o_mem_addr),
`ifdef CACHE_REFILL_STAT_EN
    .o_hit_cnt      (o_hit_cnt),
    .o_miss_cnt     (o_miss_cnt),
`endif
    .i_mem_ack      (i_mem_ack),
    .i_mem_rdata    (i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // One request: inputs change on falling edges, outputs are sampled on falling edges.
  // Expected behaviour: hit -> valid in cycle 3, no memory traffic, no write;
  // miss -> wait+1 memory cycles, one refill write, valid in cycle 4+wait.
  task automatic run_req(input logic [29:0] addr, input logic miss, input logic [7:0] caddr,
                         input logic [31:0] data, input int wait_cyc, input logic hold,
                         input logic expect_immediate);
    int   guard, cyc, lat, mem_cyc, we_cnt, cb_cnt, exp_lat, exp_mem, exp_we;
    logic prev_re, busy_err, addr_err, both_err;
    guard = 0;
    while (!o_ready && guard < 50) begin
      @(negedge i_clk);
      guard++;
    end
    checks++;
    if (o_ready !== 1'b1 || (expect_immediate && guard != 0)) begin
      errors++;
      $display("FAIL ready_wait: o_ready=%b after %0d cycles, required 1 after %0d", o_ready, guard,
               expect_immediate ? 0 : guard);
    end
    i_req = 1'b1; i_addr = addr; i_miss_cache = miss; i_cache_addr = caddr;
    exp_lat = miss ? 4 + wait_cyc : 3;
    exp_mem = miss ? wait_cyc + 1 : 0;
    exp_we  = miss ? 1 : 0;
    cyc = 0; lat = 0; mem_cyc = 0; we_cnt = 0; cb_cnt = 0;
    prev_re = 1'b0; busy_err = 1'b0; addr_err = 1'b0; both_err = 1'b0;
    while (lat == 0 && cyc < 60) begin
      @(negedge i_clk);
      cyc++;
      i_mem_ack    = 1'b0;
      i_mem_rdata  = $urandom;
      i_cram_rdata = prev_re ? data : $urandom;
      prev_re      = o_cram_re;
      if (cyc == 1) begin
        if (!hold) i_req = 1'b0;
        checks++;
        if (o_en !== 1'b1 || o_change_block !== 1'b1 ||
            (!miss && (o_cram_re !== 1'b1 || o_cram_addr !== caddr))) begin
          errors++;
          $display("FAIL lookup: en=%b cb=%b re=%b caddr=%h, required 1 1 %b %h",
                   o_en, o_change_block, o_cram_re, o_cram_addr, !miss, miss ? o_cram_addr : caddr);
        end
      end else begin
        i_addr       = 30'($urandom);
        i_cache_addr = 8'($urandom);
        i_miss_cache = 1'($urandom);
      end
      if (o_change_block) cb_cnt++;
      if (o_ready) busy_err = 1'b1;
      if (o_cram_we && o_cram_re) both_err = 1'b1;
      if (o_mem_req) begin
        mem_cyc++;
        if (o_mem_addr !== addr) addr_err = 1'b1;
        if (mem_cyc > wait_cyc) begin
          i_mem_ack   = 1'b1;
          i_mem_rdata = data;
        end
      end
      if (o_cram_we) begin
        we_cnt++;
        checks++;
        if (o_cram_addr !== caddr || o_cram_wdata !== data || o_ready_wr !== 1'b1) begin
          errors++;
          $display("FAIL fill: addr=%h wdata=%h rdy_wr=%b, required %h %h 1",
                   o_cram_addr, o_cram_wdata, o_ready_wr, caddr, data);
        end
      end
      if (o_valid) lat = cyc;
    end
    i_mem_ack = 1'b0;
    checks++;
    if (lat != exp_lat || o_rdata !== data) begin
      errors++;
      $display("FAIL response: latency=%0d rdata=%h, required %0d %h", lat, o_rdata, exp_lat, data);
    end
    checks++;
    if (mem_cyc != exp_mem || we_cnt != exp_we || cb_cnt != 1) begin
      errors++;
      $display("FAIL traffic: mem_cycles=%0d writes=%0d lookups=%0d, required %0d %0d 1",
               mem_cyc, we_cnt, cb_cnt, exp_mem, exp_we);
    end
    checks++;
    if (busy_err || addr_err || both_err) begin
      errors++;
      $display("FAIL busy_rules: ready_while_busy=%b addr_unstable=%b re_we_overlap=%b, required 0 0 0",
               busy_err, addr_err, both_err);
    end
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_rdata !== data) begin
      errors++;
      $display("FAIL after_resp: valid=%b ready=%b rdata=%h, required 0 1 %h",
               o_valid, o_ready, o_rdata, data);
    end
  endtask

  task automatic apply_reset();
    i_nreset = 1'b0;
    repeat (3) @(negedge i_clk);
    i_nreset = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_req = 1'b1; i_addr = 30'h3FF; i_miss_cache = 1'b0; i_cache_addr = 8'h11;
    i_cram_rdata = 32'hFFFF_FFFF; i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
    i_nreset = 1'b0;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_ready, o_valid, o_en, o_change_block, o_ready_wr, o_cram_re, o_cram_we, o_mem_req} !== 8'b1000_0000 ||
        o_rdata !== 32'd0 || o_cram_addr !== 8'd0 || o_cram_wdata !== 32'd0 || o_mem_addr !== 30'd0) begin
      errors++;
      $display("FAIL reset_state: ctl=%b rdata=%h caddr=%h wdata=%h maddr=%h, required 10000000 0 0 0 0",
               {o_ready, o_valid, o_en, o_change_block, o_ready_wr, o_cram_re, o_cram_we, o_mem_req},
               o_rdata, o_cram_addr, o_cram_wdata, o_mem_addr);
    end
    i_req = 1'b0; i_mem_ack = 1'b0;
    i_nreset = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_hit();
    run_req(30'h100, 1'b0, 8'h25, 32'hDEADBEEF, 0, 1'b0, 1'b1);
  endtask

  task automatic test_miss();
    run_req(30'h2A5_1234, 1'b1, 8'h41, 32'h12345678, 5, 1'b0, 1'b1);
    run_req(30'h0F0_00AB, 1'b1, 8'h7E, 32'hCAFE_F00D, 0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_req(30'h000_0140, 1'b0, 8'h01, 32'hA5A5_0001, 0, 1'b1, 1'b1);
    run_req(30'h000_0160, 1'b0, 8'h02, 32'hA5A5_0002, 0, 1'b1, 1'b1);
    run_req(30'h000_0180, 1'b0, 8'h03, 32'hA5A5_0003, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      run_req(30'($urandom), 1'($urandom), 8'($urandom), $urandom, int'($urandom_range(0, 6)),
              1'b0, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    int   guard, bad_we, bad_valid, bad_ready;
    i_req = 1'b1; i_addr = 30'h155_5555; i_miss_cache = 1'b1; i_cache_addr = 8'h9C;
    @(negedge i_clk);
    i_req = 1'b0;
    guard = 0;
    while (!o_mem_req && guard < 10) begin
      @(negedge i_clk);
      guard++;
    end
    @(negedge i_clk);
    checks++;
    if (o_mem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: o_mem_req=%b, required 1", o_mem_req);
    end
    i_nreset = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_drop_req: o_mem_req=%b, required 0", o_mem_req);
    end
    i_mem_ack = 1'b1; i_mem_rdata = 32'h5151_5151;
    @(negedge i_clk);
    i_nreset = 1'b1;
    bad_we = 0; bad_valid = 0; bad_ready = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      if (o_cram_we) bad_we++;
      if (o_valid) bad_valid++;
      if (!o_ready) bad_ready++;
    end
    i_mem_ack = 1'b0;
    checks++;
    if (bad_we != 0 || bad_valid != 0 || bad_ready != 0 || o_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_abort: writes=%0d valids=%0d not_ready=%0d rdata=%h, required 0 0 0 0",
               bad_we, bad_valid, bad_ready, o_rdata);
    end
  endtask

`ifdef CACHE_REFILL_STAT_EN
  task automatic test_stats();
    apply_reset();
    run_req(30'h000_0200, 1'b0, 8'h10, 32'h1111_1111, 0, 1'b0, 1'b1);
    run_req(30'h000_0220, 1'b1, 8'h11, 32'h2222_2222, 2, 1'b0, 1'b1);
    run_req(30'h000_0240, 1'b0, 8'h12, 32'h3333_3333, 0, 1'b0, 1'b1);
    checks++;
    if (o_hit_cnt !== 16'd2 || o_miss_cnt !== 16'd1) begin
      errors++;
      $display("FAIL stat_counts: hit=%0d miss=%0d, required 2 1", o_hit_cnt, o_miss_cnt);
    end
    force dut.hit_cnt_q = 16'hFFFF;
    @(posedge i_clk);
    #1 release dut.hit_cnt_q;
    @(negedge i_clk);
    run_req(30'h000_0260, 1'b0, 8'h13, 32'h4444_4444, 0, 1'b0, 1'b1);
    checks++;
    if (o_hit_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL stat_saturate: hit=%h, required ffff", o_hit_cnt);
    end
  endtask
`endif

  initial begin
    i_nreset = 1'b0; i_req = 1'b0; i_addr = 30'd0; i_miss_cache = 1'b0; i_cache_addr = 8'd0;
    i_cram_rdata = 32'd0; i_mem_ack = 1'b0; i_mem_rdata = 32'd0;
    @(negedge i_clk);
    test_reset();
    test_hit();
    test_miss();
    test_back_to_back();
    test_random();
    test_reset_mid();
    run_req(30'h3AB_CDEF, 1'b0, 8'hF0, 32'h0BAD_CAFE, 0, 1'b0, 1'b1);
`ifdef CACHE_REFILL_STAT_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cache_refill.md
CACHE_REFILL -- requirements
Module: cache_refill

Interface
REQ-001 SHALL have port i_clk, input, 1, single clock; all state changes on its rising edge.
REQ-002 SHALL have port i_nreset, input, 1, reset: synchronous, active-low.
REQ-003 SHALL have ports i_req (in, 1) and i_addr (in, 30): CPU read request and word address ([29:8] tag, [7:5] block, [4:0] word); o_ready (out, 1): request accepted when i_req && o_ready on a rising edge.
REQ-004 SHALL have ports o_valid (out, 1), a one-cycle response strobe, and o_rdata (out, 32), the response data.
REQ-005 SHALL have ports to the cache calculator: o_en (out, 1), o_change_block (out, 1), o_ready_wr (out, 1), i_miss_cache (in, 1), i_cache_addr (in, 8).
REQ-006 SHALL have cache data RAM ports o_cram_re (out, 1), o_cram_we (out, 1), o_cram_addr (out, 8), o_cram_wdata (out, 32), i_cram_rdata (in, 32); i_cram_rdata is valid one cycle after o_cram_re.
REQ-007 SHALL have main memory ports o_mem_req (out, 1), o_mem_addr (out, 30), i_mem_ack (in, 1), i_mem_rdata (in, 32); i_mem_rdata is valid in the cycle i_mem_ack=1.

Function
REQ-008 SHALL implement FSM states IDLE, LOOKUP, HIT_RD, MEM_REQ, FILL, RESP.
REQ-009 IDLE: o_ready=1; on acceptance, SHALL latch i_addr into addr_q and go to LOOKUP; all other outputs inactive.
REQ-010 LOOKUP (exactly one cycle per request): o_en=1 and o_change_block=1, i_addr driven from addr_q by the integrator; o_en and o_change_block SHALL be 0 in every other state.
REQ-011 LOOKUP with i_miss_cache=0: o_cram_re=1, o_cram_addr=i_cache_addr; next state HIT_RD.
REQ-012 LOOKUP with i_miss_cache=1: SHALL latch i_cache_addr into caddr_q; next state MEM_REQ.
REQ-013 HIT_RD: SHALL capture i_cram_rdata into o_rdata; next state RESP.
REQ-014 MEM_REQ: o_mem_req=1, o_mem_addr=addr_q, held stable until i_mem_ack; on i_mem_ack=1, capture i_mem_rdata into data_q and o_rdata, then go to FILL. An ack in the first MEM_REQ cycle SHALL be honoured.
REQ-015 FILL (one cycle): o_cram_we=1, o_cram_addr=caddr_q, o_cram_wdata=data_q, o_ready_wr=1; next state RESP.
REQ-016 RESP (one cycle): o_valid=1; next state IDLE; o_rdata SHALL hold its value until the next capture.
REQ-017 Latency from acceptance edge to o_valid: hit 3 cycles; miss 4 cycles plus ack wait cycles.
REQ-018 o_ready SHALL be 0 outside IDLE; i_req outside IDLE SHALL be ignored and not queued.
REQ-019 i_mem_ack outside MEM_REQ SHALL be ignored; o_cram_we and o_cram_re SHALL never be asserted in the same cycle.
REQ-020 Back-to-back requests: a request held high across RESP SHALL be accepted in the following IDLE cycle, giving a 1-cycle bubble minimum.

Reset
REQ-021 When i_nreset=0 at a rising edge: state=IDLE, addr_q=0, caddr_q=0, data_q=0, o_rdata=0; o_ready=1 and all other outputs 0 in the following cycle.
REQ-022 Reset mid-operation, including MEM_REQ, SHALL abort without a cache write; o_mem_req drops in the first reset cycle; a late ack is ignored.

Configuration
REQ-023 Macro CACHE_REFILL_STAT_EN defined: SHALL add outputs o_hit_cnt (16) and o_miss_cnt (16), incremented in LOOKUP on hit and miss respectively, saturating at 16'hFFFF and cleared by reset.
REQ-024 Macro CACHE_REFILL_STAT_EN undefined: the counters and ports SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-025 Hit: i_addr=30'h100, i_miss_cache=0, i_cache_addr=8'h25, i_cram_rdata=32'hDEADBEEF -> o_cram_addr=8'h25 in LOOKUP; o_valid at +3 with o_rdata=32'hDEADBEEF; o_mem_req never asserted.
REQ-026 Miss, ack after 5 cycles: i_miss_cache=1, i_cache_addr=8'h41, i_mem_rdata=32'h12345678 -> o_mem_addr=addr_q held stable; FILL writes 8'h41 with 32'h12345678 and o_ready_wr=1; o_valid 1 cycle later.
REQ-027 Miss with ack in the first MEM_REQ cycle -> o_valid at +4 cycles; exactly one o_cram_we pulse.
REQ-028 Reset asserted during MEM_REQ, then ack -> no o_cram_we, no o_valid; o_ready=1 after reset.
REQ-029 i_req held high continuously for 3 hits -> exactly 3 accepts, one o_change_block pulse each, o_ready low while busy.
REQ-030 CACHE_REFILL_STAT_EN defined: 2 hits + 1 miss -> o_hit_cnt=2, o_miss_cnt=1; counter forced to 16'hFFFF plus one hit -> remains 16'hFFFF.
